mem_access_stage: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs data-memory loads and stores over a req/gnt + rvalid handshake with a multi-cycle memory.
- Stalls the upstream pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_access_stage.sv | 139 +++++++++++++
 tb/tb_mem_access_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory loads/stores over req/gnt + rvalid, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [4:0]        mdestReg,
    input  logic [DATA_W-1:0] mr,
    input  logic [DATA_W-1:0] mqb,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wwreg,
    output logic              wm2reg,
    output logic [4:0]        wdestReg,
    output logic [DATA_W-1:0] wr,
    output logic [DATA_W-1:0] wdo,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              access;
    logic              is_load;
    logic              mis_now;
    logic              trap;
    logic [DATA_W-1:0] rdata_hold;

    assign access  = mm2reg | mwmem;
    assign is_load = mm2reg;
    assign stall   = access & (state != DONE);
    assign dmem_req = (state == REQ);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_pend;
    logic mis_flag;

    assign mis_now  = access & (mr[1:0] != 2'b00);
    assign trap     = (state == DONE) & mis_pend;
    assign misalign = mis_flag;

    // Remember a trapped access until its DONE; sticky flag until reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mis_pend <= 1'b0;
            mis_flag <= 1'b0;
        end else begin
            if (state == IDLE && access)
                mis_pend <= mis_now;
            if (trap)
                mis_flag <= 1'b1;
        end
    end
`else
    assign mis_now  = 1'b0;
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic for the access handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (access)      state_nxt = mis_now ? DONE : REQ;
            REQ:  if (dmem_gnt)    state_nxt = is_load ? RESP : DONE;
            RESP: if (dmem_rvalid) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Capture the request on entry and the load data on response.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata_hold <= '0;
        end else begin
            if (state == IDLE && access) begin
                dmem_we    <= mwmem & ~mm2reg;
                dmem_addr  <= {mr[DATA_W-1:2], 2'b00};
                dmem_wdata <= mqb;
            end
            if (state == RESP && dmem_rvalid)
                rdata_hold <= dmem_rdata;
        end
    end

    // MEM/WB register: bubble while stalled, else take the instruction.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wwreg    <= 1'b0;
            wm2reg   <= 1'b0;
            wdestReg <= '0;
            wr       <= '0;
            wdo      <= '0;
        end else if (stall) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else begin
            wwreg    <= mwreg & ~trap;
            wm2reg   <= mm2reg & ~trap;
            wdestReg <= mdestReg;
            wr       <= mr;
            wdo      <= (state == DONE && is_load && !trap) ? rdata_hold : '0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            stall_cnt <= '0;
        else if (stall && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage, default and CNT_W=3 instances.
// Misaligned expectations follow MEM_MISALIGN_TRAP_EN.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem;
    logic [4:0]  mdestReg;
    logic [31:0] mr, mqb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        wwreg, wm2reg;
    logic [4:0]  wdestReg;
    logic [31:0] wr, wdo;
    logic [15:0] stall_cnt;
    logic        misalign;

    logic        s_stall, s_req, s_we, s_wwreg, s_wm2reg, s_mis;
    logic [31:0] s_addr, s_wdata, s_wr, s_wdo;
    logic [4:0]  s_dest;
    logic [2:0]  s_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_stage u_dut (
        .clk(clk), .clrn(clrn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mdestReg(mdestReg), .mr(mr), .mqb(mqb),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg),
        .wr(wr), .wdo(wdo), .stall_cnt(stall_cnt),
        .misalign(misalign)
    );

    mem_access_stage #(.CNT_W(3)) u_sat (
        .clk(clk), .clrn(clrn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .mdestReg(mdestReg), .mr(mr), .mqb(mqb),
        .stall(s_stall), .dmem_req(s_req), .dmem_we(s_we),
        .dmem_addr(s_addr), .dmem_wdata(s_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata),
        .wwreg(s_wwreg), .wm2reg(s_wm2reg), .wdestReg(s_dest),
        .wr(s_wr), .wdo(s_wdo), .stall_cnt(s_cnt),
        .misalign(s_mis)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mwreg = 0; mm2reg = 0; mwmem = 0;
        mdestReg = 0; mr = 0; mqb = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_in();
        clrn = 0;
        #12;
        clrn = 1;
        tick();
    endtask

    initial begin
        idle_in();
        do_reset();

        // reset state
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wwreg", wwreg, 0);
        check("rst_wr", wr, 0);
        check("rst_cnt", stall_cnt, 0);
        check("rst_mis", misalign, 0);

        // ALU op
        mwreg = 1; mdestReg = 5; mr = 32'h1234;
        #1 check("alu_stall", stall, 0);
        tick();
        check("alu_wwreg", wwreg, 1);
        check("alu_dest", wdestReg, 5);
        check("alu_wr", wr, 32'h1234);
        check("alu_wdo", wdo, 0);
        check("alu_cnt", stall_cnt, 0);
        idle_in();
        tick();

        // store, gnt low for 3 cycles
        begin
            int nreq = 0;
            int nstl = 0;
            mwmem = 1; mr = 32'h100; mqb = 32'hDEADBEEF;
            for (int i = 0; i < 6; i++) begin
                dmem_gnt = (i == 4);
                #1;
                if (dmem_req) begin
                    nreq++;
                    check("st_addr", dmem_addr, 32'h100);
                    check("st_data", dmem_wdata, 32'hDEADBEEF);
                    check("st_we", dmem_we, 1);
                end
                if (stall) nstl++;
                check("st_wwreg", wwreg, 0);
                tick();
            end
            check("st_nreq", nreq, 4);
            check("st_nstall", nstl, 5);
            check("st_cnt", stall_cnt, 5);
            check("st_wwreg_end", wwreg, 0);
            idle_in();
            tick();
        end

        // load with immediate gnt, rvalid two cycles later
        do_reset();
        mm2reg = 1; mwreg = 1; mdestReg = 9; mr = 32'h200;
        #1 check("ld_stall0", stall, 1);
        tick();
        dmem_gnt = 1;
        #1 check("ld_req", dmem_req, 1);
        check("ld_we", dmem_we, 0);
        check("ld_addr", dmem_addr, 32'h200);
        tick();
        dmem_gnt = 0;
        check("ld_req_drop", dmem_req, 0);
        check("ld_bub1", wwreg, 0);
        tick();
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        check("ld_bub2", wwreg, 0);
        tick();
        dmem_rvalid = 0; dmem_rdata = 0;
        #1 check("ld_done_stall", stall, 0);
        check("ld_bub3", wwreg, 0);
        tick();
        check("ld_wwreg", wwreg, 1);
        check("ld_wm2reg", wm2reg, 1);
        check("ld_wdo", wdo, 32'hCAFEF00D);
        check("ld_dest", wdestReg, 9);
        check("ld_cnt", stall_cnt, 4);
        idle_in();
        tick();
        check("ld_single", wwreg, 0);

        // reset in the middle of a load
        mm2reg = 1; mwreg = 1; mdestReg = 7; mr = 32'h400;
        tick();
        dmem_gnt = 1;
        tick();
        idle_in();
        clrn = 0;
        #1;
        check("mr_req", dmem_req, 0);
        check("mr_stall", stall, 0);
        check("mr_wwreg", wwreg, 0);
        check("mr_dest", wdestReg, 0);
        check("mr_wr", wr, 0);
        check("mr_wdo", wdo, 0);
        check("mr_cnt", stall_cnt, 0);
        #10 clrn = 1;
        tick();
        dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
        tick();
        idle_in();
        tick();
        check("mr_wdo_after", wdo, 0);
        check("mr_stall_after", stall, 0);

        // long stall: 12 cycles, 3-bit counter saturates
        do_reset();
        mwmem = 1; mr = 32'h300; mqb = 32'h1;
        for (int i = 0; i < 12; i++) begin
            dmem_gnt = (i == 11);
            tick();
        end
        dmem_gnt = 0;
        check("sat_cnt16", stall_cnt, 12);
        check("sat_cnt3", s_cnt, 7);
        idle_in();
        tick();

        // misaligned load
        do_reset();
        mm2reg = 1; mwreg = 1; mdestReg = 3; mr = 32'h203;
`ifdef MEM_MISALIGN_TRAP_EN
        tick();
        #1 check("mis_req", dmem_req, 0);
        check("mis_stall", stall, 0);
        tick();
        check("mis_flag", misalign, 1);
        check("mis_wwreg", wwreg, 0);
        idle_in();
        tick();
        tick();
        check("mis_sticky", misalign, 1);
        check("mis_wwreg2", wwreg, 0);
`else
        tick();
        dmem_gnt = 1;
        #1 check("mis_req", dmem_req, 1);
        check("mis_addr", dmem_addr, 32'h200);
        tick();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h11;
        tick();
        dmem_rvalid = 0;
        tick();
        check("mis_wwreg", wwreg, 1);
        check("mis_wdo", wdo, 32'h11);
        check("mis_flag", misalign, 0);
        idle_in();
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
